// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, field-position and fetch-state definitions
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_JAL) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_LW)  ||
               (op == OP_SW);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC mux: jump target, taken branch, or pc+4
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        unused_opcode;

    assign jump_target   = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    assign branch_target = pc_plus4 + {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
    assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

    // jump is tested first so an undriven branch from the decoder on j cannot leak in
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, imem req/ack fetch FSM, retire counter
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         req_q, req_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
            end
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // control inputs only matter on the retiring cycle
                if (exec_done) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    count_d = count_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            count_q <= count_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign instr_count = count_q;

endmodule
